fakeram7_tdp_64x32_arbiter: RTL and testbench
=============================================

Name: fakeram7_tdp_64x32_arbiter

Overview:
Shares one 64x32 true-dual-port fakeram7 macro between NREQ single-cycle requesters, with round-robin fairness. Each cycle it grants up to two requests, one on RAM port A and one on port B. A same-address collision that involves a write is serialized. Read data is routed back to the owning requester one cycle after grant. The block sits between client logic and the RAM macro, and both RAM clocks are tied to clk.

Parameters:
NREQ, 4, number of requesters (2..8)
BITS, 32, data/mask width (matches macro)
ADDR_WIDTH, 6, word address width (64 words)
IDW, 2, requester index width, $clog2(NREQ)

Ports:
clk  in  1  clock for arbiter; also drives RAM clk_A and clk_B externally
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  request pending, per requester
req_ready  out  NREQ  grant this cycle; combinational from req_valid/state
req_we  in  NREQ  1=write, 0=read
req_addr  in  NREQ*ADDR_WIDTH  word address, requester i at slice i
req_wdata  in  NREQ*BITS  write data
req_wmask  in  NREQ*BITS  per-bit write mask, 1=write bit
rsp_valid  out  NREQ  read data valid pulse
rsp_data  out  NREQ*BITS  read data; slice is 0 when rsp_valid[i]=0
ram_ce_A / ram_ce_B  out  1  RAM chip enable, per port
ram_we_A / ram_we_B  out  1  RAM write enable
ram_addr_A / ram_addr_B  out  ADDR_WIDTH  RAM address
ram_wd_A / ram_wd_B  out  BITS  RAM write data
ram_wmask_A / ram_wmask_B  out  BITS  RAM write mask
ram_rd_A / ram_rd_B  in  BITS  RAM registered read data

Behaviour:
- State:
  - rr_ptr[IDW], the requester with highest priority.
  - pendA/pendB valid bits, each with an owner id[IDW].
- Reset (rst=1 at posedge):
  - rr_ptr=0; pendA=pendB=0.
  - While rst=1: all req_ready=0, ram_ce_*=0, rsp_valid=0.
- Grant selection (combinational; valid only when rst=0):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NREQ.
  - First valid requester = gA, granted on port A.
  - Next valid requester = gB, granted on port B.
- Conflict rule:
  - Condition: gA and gB both exist, req_addr equal, and req_we[gA] or req_we[gB] is 1.
  - Action: gB is not granted this cycle.
  - Two reads to the same address are both granted.
- req_ready[i]=1 iff i is gA or a granted gB.
  - A request is consumed when valid&ready.
  - Requesters must not make valid depend on ready.
- Port drive:
  - Granted port: ce=1; we/addr/wd/wmask copied from the owner.
  - Idle port: ce=0, we=0, addr=0, wd=0, wmask=0. Never drive X to the macro.
- Pointer update at posedge:
  - If any grant: rr_ptr = (last granted index + 1) mod NREQ. The last granted index is gB if granted, else gA.
  - No grant: rr_ptr unchanged.
- Read latency is exactly 1 cycle:
  - Granted read on port A at cycle t: set pendA=1, idA=gA.
  - At cycle t+1: rsp_valid[idA]=1 and rsp_data[idA]=ram_rd_A. Port B behaves the same.
  - A granted write clears the port's pend bit and produces no response.
- Both ports may respond to the same requester only if it was granted twice, which is impossible. At most one response per requester per cycle.
- Back-to-back: a requester may be granted every cycle. Its responses stream at one per cycle.
- Write then read of the same address in consecutive cycles returns the new data. RAM write occurs at the grant edge.
- Reset mid-operation: pending reads are dropped and no rsp_valid is issued after reset.
- Implementation: registers are limited to rr_ptr and the pend/id pairs; everything else is combinational. Target 150-250 lines.

Test Plan:
1. Reset: assert rst 2 cycles with all req_valid=1 -> req_ready=0, ram_ce_A=ram_ce_B=0, rsp_valid=0. After release, first grant is gA=0, gB=1.
2. Write/read: req0 writes addr 5, data 0xDEADBEEF, mask 0xFFFFFFFF. Next cycle req0 reads addr 5 -> one cycle later rsp_valid=4'b0001, rsp_data[0]=0xDEADBEEF.
3. Masked write: mem[9]=0x00000000; write 0xFFFFFFFF with mask 0x0000FF00; then read -> 0x0000FF00.
4. Fairness: all 4 requesters hold reads at distinct addresses -> grants (0,1), (2,3), (0,1), ... Each requester receives one response per 2 cycles.
5. Conflict: req1 writes addr 7 while req2 reads addr 7, rr_ptr=1 -> only req1 granted. Next cycle req2 is granted (rr_ptr=2) and reads the new data. Two reads of addr 7 are granted together.
6. Reset mid-read: grant reads on both ports, then assert rst the next cycle -> no rsp_valid is ever asserted for those reads. rr_ptr returns to 0.

Source files
------------

// File: rtl/fakeram7_tdp_64x32_arbiter.sv
// Round-robin arbiter sharing one 64x32 true-dual-port fakeram7 macro.
// Grants up to two requesters per cycle (ports A/B) and routes read data back.
module fakeram7_tdp_64x32_arbiter #(
   parameter int NREQ       = 4,
   parameter int BITS       = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int IDW        = $clog2(NREQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ-1:0]            req_we,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NREQ*BITS-1:0]       req_wdata,
   input  logic [NREQ*BITS-1:0]       req_wmask,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [NREQ*BITS-1:0]       rsp_data,
   output logic                       ram_ce_A,
   output logic                       ram_we_A,
   output logic [ADDR_WIDTH-1:0]      ram_addr_A,
   output logic [BITS-1:0]            ram_wd_A,
   output logic [BITS-1:0]            ram_wmask_A,
   input  logic [BITS-1:0]            ram_rd_A,
   output logic                       ram_ce_B,
   output logic                       ram_we_B,
   output logic [ADDR_WIDTH-1:0]      ram_addr_B,
   output logic [BITS-1:0]            ram_wd_B,
   output logic [BITS-1:0]            ram_wmask_B,
   input  logic [BITS-1:0]            ram_rd_B
);

   localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

   logic [IDW-1:0]        rr_ptr;
   logic                  pend_a;
   logic                  pend_b;
   logic [IDW-1:0]        id_a;
   logic [IDW-1:0]        id_b;

   logic [ADDR_WIDTH-1:0] addr_v [NREQ];
   logic [BITS-1:0]       wd_v   [NREQ];
   logic [BITS-1:0]       wm_v   [NREQ];

   logic                  ga_vld;
   logic                  gb_vld;
   logic [IDW-1:0]        ga;
   logic [IDW-1:0]        gb;
   logic [IDW:0]          scan_sum;
   logic [IDW-1:0]        scan_idx;
   logic                  conflict;
   logic                  gb_gnt;
   logic [IDW-1:0]        last_gnt;
   logic [IDW:0]          nxt_sum;
   logic [IDW-1:0]        rr_nxt;

   // Split the flat request buses into per-requester fields
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         addr_v[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         wd_v[i]   = req_wdata[i*BITS +: BITS];
         wm_v[i]   = req_wmask[i*BITS +: BITS];
      end
   end

   // Scan from rr_ptr: first valid goes to port A, next valid to port B
   always_comb begin
      ga_vld   = 1'b0;
      gb_vld   = 1'b0;
      ga       = '0;
      gb       = '0;
      scan_sum = '0;
      scan_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (scan_sum >= NREQ_W)
            scan_sum = scan_sum - NREQ_W;
         scan_idx = scan_sum[IDW-1:0];
         if (!rst && req_valid[scan_idx]) begin
            if (!ga_vld) begin
               ga_vld = 1'b1;
               ga     = scan_idx;
            end else if (!gb_vld) begin
               gb_vld = 1'b1;
               gb     = scan_idx;
            end
         end
      end
   end

   // Same-address pair involving a write is serialized: B waits
   assign conflict = ga_vld && gb_vld
                  && (addr_v[ga] == addr_v[gb])
                  && (req_we[ga] || req_we[gb]);
   assign gb_gnt   = gb_vld && !conflict;

   // Ready one-hot per granted requester
   always_comb begin
      req_ready = '0;
      if (ga_vld)
         req_ready[ga] = 1'b1;
      if (gb_gnt)
         req_ready[gb] = 1'b1;
   end

   // Drive both macro ports; idle ports get all-zero, never X
   always_comb begin
      ram_ce_A    = ga_vld;
      ram_we_A    = ga_vld ? req_we[ga] : 1'b0;
      ram_addr_A  = ga_vld ? addr_v[ga] : '0;
      ram_wd_A    = ga_vld ? wd_v[ga]   : '0;
      ram_wmask_A = ga_vld ? wm_v[ga]   : '0;
      ram_ce_B    = gb_gnt;
      ram_we_B    = gb_gnt ? req_we[gb] : 1'b0;
      ram_addr_B  = gb_gnt ? addr_v[gb] : '0;
      ram_wd_B    = gb_gnt ? wd_v[gb]   : '0;
      ram_wmask_B = gb_gnt ? wm_v[gb]   : '0;
   end

   // Next priority pointer: one past the last granted requester
   always_comb begin
      last_gnt = gb_gnt ? gb : ga;
      nxt_sum  = {1'b0, last_gnt} + (IDW+1)'(1);
      if (nxt_sum >= NREQ_W)
         nxt_sum = '0;
      rr_nxt   = nxt_sum[IDW-1:0];
   end

   // Pointer and pending-read tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
         pend_a <= 1'b0;
         pend_b <= 1'b0;
         id_a   <= '0;
         id_b   <= '0;
      end else begin
         if (ga_vld)
            rr_ptr <= rr_nxt;
         pend_a <= ga_vld && !req_we[ga];
         pend_b <= gb_gnt && !req_we[gb];
         id_a   <= ga;
         id_b   <= gb;
      end
   end

   // Route registered macro read data back to the owning requester
   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!rst && pend_a && (id_a == IDW'(i))) begin
            rsp_valid[i]             = 1'b1;
            rsp_data[i*BITS +: BITS] = ram_rd_A;
         end else if (!rst && pend_b && (id_b == IDW'(i))) begin
            rsp_valid[i]             = 1'b1;
            rsp_data[i*BITS +: BITS] = ram_rd_B;
         end
      end
   end

endmodule

// File: tb/tb_fakeram7_tdp_64x32_arbiter.sv
// Bench for fakeram7_tdp_64x32_arbiter with a behavioural dual-port RAM.
// Vector table plus response scoreboard and a fairness count sequence.
module tb_fakeram7_tdp_64x32_arbiter;

   localparam int NREQ = 4;
   localparam int BITS = 32;
   localparam int AW   = 6;

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      req_we;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*BITS-1:0] req_wdata;
   logic [NREQ*BITS-1:0] req_wmask;
   logic [NREQ-1:0]      rsp_valid;
   logic [NREQ*BITS-1:0] rsp_data;
   logic                 ram_ce_A, ram_we_A, ram_ce_B, ram_we_B;
   logic [AW-1:0]        ram_addr_A, ram_addr_B;
   logic [BITS-1:0]      ram_wd_A, ram_wmask_A, ram_rd_A;
   logic [BITS-1:0]      ram_wd_B, ram_wmask_B, ram_rd_B;

   fakeram7_tdp_64x32_arbiter #(
      .NREQ(NREQ), .BITS(BITS), .ADDR_WIDTH(AW), .IDW(2)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .ram_ce_A(ram_ce_A), .ram_we_A(ram_we_A),
      .ram_addr_A(ram_addr_A), .ram_wd_A(ram_wd_A),
      .ram_wmask_A(ram_wmask_A), .ram_rd_A(ram_rd_A),
      .ram_ce_B(ram_ce_B), .ram_we_B(ram_we_B),
      .ram_addr_B(ram_addr_B), .ram_wd_B(ram_wd_B),
      .ram_wmask_B(ram_wmask_B), .ram_rd_B(ram_rd_B)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural macro: write at edge, registered read data
   logic [BITS-1:0] mem [64];
   logic            ram_load;
   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 64; i++)
            mem[i] <= 32'hA000_0000 | i;
         ram_rd_A <= '0;
         ram_rd_B <= '0;
      end else begin
         if (ram_ce_A) begin
            if (ram_we_A)
               mem[ram_addr_A] <= (mem[ram_addr_A] & ~ram_wmask_A)
                                | (ram_wd_A & ram_wmask_A);
            else
               ram_rd_A <= mem[ram_addr_A];
         end
         if (ram_ce_B) begin
            if (ram_we_B)
               mem[ram_addr_B] <= (mem[ram_addr_B] & ~ram_wmask_B)
                                | (ram_wd_B & ram_wmask_B);
            else
               ram_rd_B <= mem[ram_addr_B];
         end
      end
   end

   typedef struct {
      logic            r;
      logic [3:0]      vl;
      logic [3:0]      we;
      logic [23:0]     ad;
      logic [31:0]     w;
      logic [31:0]     m;
      logic [3:0]      rdy;
      logic [1:0]      ce;
      logic [11:0]     ra;
      logic [3:0]      rv;
      logic [127:0]    rd;
   } vec_t;

   typedef struct {
      logic [3:0]   v;
      logic [127:0] d;
   } exp_t;

   vec_t tbl [23];
   exp_t sbq [$];
   int   n_chk;
   int   n_pass;
   int   cnt [NREQ];

   function automatic vec_t mk(
      input logic r, input logic [3:0] vl, input logic [3:0] we,
      input logic [23:0] ad, input logic [31:0] w, input logic [31:0] m,
      input logic [3:0] rdy, input logic [1:0] ce, input logic [11:0] ra,
      input logic [3:0] rv, input logic [127:0] rd);
      vec_t v;
      v.r = r; v.vl = vl; v.we = we; v.ad = ad; v.w = w; v.m = m;
      v.rdy = rdy; v.ce = ce; v.ra = ra; v.rv = rv; v.rd = rd;
      return v;
   endfunction

   task automatic check(input string nm, input int row,
                        input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
   endtask

   task automatic step(input vec_t v, input int row);
      exp_t e;
      @(negedge clk);
      rst       = v.r;
      req_valid = v.vl;
      req_we    = v.we;
      req_addr  = v.ad;
      req_wdata = {4{v.w}};
      req_wmask = {4{v.m}};
      #1;
      check("ready", row, 128'(req_ready), 128'(v.rdy));
      check("ce", row, 128'({ram_ce_A, ram_ce_B}), 128'(v.ce));
      check("addr", row, 128'({ram_addr_A, ram_addr_B}), 128'(v.ra));
      if (sbq.size() == 0) begin
         check("sb_empty", row, 128'(1), 128'(0));
      end else begin
         e = sbq.pop_front();
         check("rsp_v", row, 128'(rsp_valid), 128'(e.v));
         check("rsp_d", row, rsp_data, e.d);
      end
      e.v = v.rv;
      e.d = v.rd;
      sbq.push_back(e);
   endtask

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      rst       = 1'b1;
      ram_load  = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_wmask = '0;

      // reset with all valid, then first grant pair
      tbl[0]  = mk(1, 4'b1111, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 0);
      tbl[1]  = mk(1, 4'b1111, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 0);
      tbl[2]  = mk(0, 4'b1111, 0, {6'd4, 6'd3, 6'd2, 6'd1}, 0, 0,
                   4'b0011, 2'b11, {6'd1, 6'd2}, 4'b0011,
                   {32'h0, 32'h0, 32'hA000_0002, 32'hA000_0001});
      // full write then read of addr 5
      tbl[3]  = mk(0, 4'b0001, 4'b0001, {18'd0, 6'd5},
                   32'hDEAD_BEEF, 32'hFFFF_FFFF,
                   4'b0001, 2'b10, {6'd5, 6'd0}, 0, 0);
      tbl[4]  = mk(0, 4'b0001, 0, {18'd0, 6'd5}, 0, 0,
                   4'b0001, 2'b10, {6'd5, 6'd0}, 4'b0001,
                   {96'h0, 32'hDEAD_BEEF});
      // masked write on addr 9
      tbl[5]  = mk(0, 4'b0001, 4'b0001, {18'd0, 6'd9},
                   32'h0000_0000, 32'hFFFF_FFFF,
                   4'b0001, 2'b10, {6'd9, 6'd0}, 0, 0);
      tbl[6]  = mk(0, 4'b0001, 4'b0001, {18'd0, 6'd9},
                   32'hFFFF_FFFF, 32'h0000_FF00,
                   4'b0001, 2'b10, {6'd9, 6'd0}, 0, 0);
      tbl[7]  = mk(0, 4'b0001, 0, {18'd0, 6'd9}, 0, 0,
                   4'b0001, 2'b10, {6'd9, 6'd0}, 4'b0001,
                   {96'h0, 32'h0000_FF00});
      // lone requester 3 moves priority back to 0
      tbl[8]  = mk(0, 4'b1000, 0, {6'd10, 18'd0}, 0, 0,
                   4'b1000, 2'b10, {6'd10, 6'd0}, 4'b1000,
                   {32'hA000_000A, 96'h0});
      // fairness: all four reading distinct addresses
      tbl[9]  = mk(0, 4'b1111, 0, {6'd19, 6'd18, 6'd17, 6'd16}, 0, 0,
                   4'b0011, 2'b11, {6'd16, 6'd17}, 4'b0011,
                   {64'h0, 32'hA000_0011, 32'hA000_0010});
      tbl[10] = mk(0, 4'b1111, 0, {6'd19, 6'd18, 6'd17, 6'd16}, 0, 0,
                   4'b1100, 2'b11, {6'd18, 6'd19}, 4'b1100,
                   {32'hA000_0013, 32'hA000_0012, 64'h0});
      tbl[11] = tbl[9];
      tbl[12] = tbl[10];
      // bring priority to 1
      tbl[13] = mk(0, 4'b0001, 0, {18'd0, 6'd20}, 0, 0,
                   4'b0001, 2'b10, {6'd20, 6'd0}, 4'b0001,
                   {96'h0, 32'hA000_0014});
      // write/read collision on addr 7, then serialized read
      tbl[14] = mk(0, 4'b0110, 4'b0010, {6'd0, 6'd7, 6'd7, 6'd0},
                   32'hCAFE_F00D, 32'hFFFF_FFFF,
                   4'b0010, 2'b10, {6'd7, 6'd0}, 0, 0);
      tbl[15] = mk(0, 4'b0100, 0, {6'd0, 6'd7, 6'd7, 6'd0},
                   32'hCAFE_F00D, 32'hFFFF_FFFF,
                   4'b0100, 2'b10, {6'd7, 6'd0}, 4'b0100,
                   {32'h0, 32'hCAFE_F00D, 64'h0});
      // two reads of the same address go together
      tbl[16] = mk(0, 4'b0110, 0, {6'd0, 6'd7, 6'd7, 6'd0}, 0, 0,
                   4'b0110, 2'b11, {6'd7, 6'd7}, 4'b0110,
                   {32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0});
      // read on A, write on B same address: write must wait
      tbl[17] = mk(0, 4'b1001, 4'b0001, {6'd7, 12'd0, 6'd7},
                   32'h1234_5678, 32'hFFFF_FFFF,
                   4'b1000, 2'b10, {6'd7, 6'd0}, 4'b1000,
                   {32'hCAFE_F00D, 96'h0});
      tbl[18] = mk(0, 4'b0001, 0, {18'd0, 6'd7}, 0, 0,
                   4'b0001, 2'b10, {6'd7, 6'd0}, 4'b0001,
                   {96'h0, 32'hCAFE_F00D});
      // reads on both ports, reset lands on the response cycle
      tbl[19] = mk(0, 4'b0011, 0, {12'd0, 6'd2, 6'd1}, 0, 0,
                   4'b0011, 2'b11, {6'd2, 6'd1}, 0, 0);
      tbl[20] = mk(1, 4'b1111, 0, {12'd0, 6'd2, 6'd1}, 0, 0,
                   4'b0000, 2'b00, 0, 0, 0);
      tbl[21] = mk(0, 4'b0111, 0, {6'd0, 6'd5, 6'd4, 6'd3}, 0, 0,
                   4'b0011, 2'b11, {6'd3, 6'd4}, 4'b0011,
                   {64'h0, 32'hA000_0004, 32'hA000_0003});
      tbl[22] = mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      ram_load = 1'b0;

      begin
         exp_t e0;
         e0.v = '0;
         e0.d = '0;
         sbq.push_back(e0);
      end

      for (int r = 0; r < 23; r++)
         step(tbl[r], r);

      // back-to-back reads from one requester stream one per cycle
      for (int k = 0; k < 4; k++) begin
         logic [5:0]  a;
         logic [31:0] d;
         a = 6'(32 + k);
         d = 32'hA000_0020 + 32'(k);
         step(mk(0, 4'b0100, 0, {6'd0, a, 12'd0}, 0, 0,
                 4'b0100, 2'b10, {a, 6'd0}, 4'b0100,
                 {32'h0, d, 64'h0}), 100 + k);
      end
      step(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 0), 104);

      // sustained contention: each requester answered once per 2 cycles
      for (int i = 0; i < NREQ; i++)
         cnt[i] = 0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         req_valid = (c < 8) ? 4'b1111 : 4'b0000;
         req_we    = '0;
         req_addr  = {6'd43, 6'd42, 6'd41, 6'd40};
         #1;
         for (int i = 0; i < NREQ; i++)
            if (rsp_valid[i])
               cnt[i]++;
      end
      for (int i = 0; i < NREQ; i++)
         check("fair_cnt", 200 + i, 128'(cnt[i]), 128'(4));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
